// File: rtl/uart_pkt_pkg.sv
// Shared constants and state encoding for the UART packet parser.
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CHK
  } parser_state_t;

endpackage

// File: rtl/pkt_timeout_timer.sv
// Inter-byte timeout counter: cleared on demand, counts while enabled and
// holds at the limit so expiry stays asserted until the next clear.
module pkt_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && count != LIMIT)
      count <= count + CW'(1);
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/uart_packet_parser.sv
// Frames SYNC/CMD/LEN/payload/CHK packets from a UART byte stream and
// presents checksum-correct packets on a valid/ready output register.
module uart_packet_parser
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     pkt_ready,
  output logic                     pkt_valid,
  output logic [7:0]               pkt_cmd,
  output logic [7:0]               pkt_len,
  output logic [8*MAX_PAYLOAD-1:0] pkt_payload,
  output logic                     chk_err,
  output logic                     len_err,
  output logic                     timeout_err,
  output logic                     drop_err,
  output logic                     busy
);

  localparam int unsigned IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  parser_state_t state, state_d;
  logic [7:0] cmd_q, cmd_d, len_q, len_d, xor_q, xor_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [MAX_PAYLOAD-1:0][7:0] wbuf_q, wbuf_d;
  logic good, chk_err_d, len_err_d, tmo_d, expired;

  pkt_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid || state == IDLE),
    .enable  (state != IDLE),
    .expired (expired)
  );

  always_comb begin
    state_d   = state;
    cmd_d     = cmd_q;
    len_d     = len_q;
    xor_d     = xor_q;
    idx_d     = idx_q;
    wbuf_d    = wbuf_q;
    good      = 1'b0;
    chk_err_d = 1'b0;
    len_err_d = 1'b0;
    tmo_d     = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: if (rx_data == SYNC_BYTE) begin
          state_d = CMD;
          wbuf_d  = '0;
        end
        CMD: begin
          cmd_d   = rx_data;
          xor_d   = rx_data;
          state_d = LEN;
        end
        LEN: if (rx_data > 8'(MAX_PAYLOAD)) begin
          len_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          len_d   = rx_data;
          xor_d   = xor_q ^ rx_data;
          idx_d   = '0;
          state_d = (rx_data == 8'd0) ? CHK : PAYLOAD;
        end
        PAYLOAD: begin
          wbuf_d[idx_q] = rx_data;
          xor_d         = xor_q ^ rx_data;
          if (8'(idx_q) == len_q - 8'd1)
            state_d = CHK;
          else
            idx_d = idx_q + IDX_W'(1);
        end
        CHK: begin
          state_d = IDLE;
          if (rx_data != xor_q)
            chk_err_d = 1'b1;
          else
            good = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (expired && state != IDLE) begin
      // A byte arriving in the expiry cycle wins; only a silent cycle times out.
      tmo_d   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cmd_q  <= '0;
      len_q  <= '0;
      xor_q  <= '0;
      idx_q  <= '0;
      wbuf_q <= '0;
    end else begin
      state  <= state_d;
      cmd_q  <= cmd_d;
      len_q  <= len_d;
      xor_q  <= xor_d;
      idx_q  <= idx_d;
      wbuf_q <= wbuf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_valid   <= 1'b0;
      pkt_cmd     <= '0;
      pkt_len     <= '0;
      pkt_payload <= '0;
      chk_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      chk_err     <= chk_err_d;
      len_err     <= len_err_d;
      timeout_err <= tmo_d;
      drop_err    <= good && pkt_valid && !pkt_ready;
      // A transfer in the same cycle frees the slot for the new packet.
      if (good && (!pkt_valid || pkt_ready)) begin
        pkt_valid   <= 1'b1;
        pkt_cmd     <= cmd_q;
        pkt_len     <= len_q;
        pkt_payload <= wbuf_q;
      end else if (pkt_valid && pkt_ready) begin
        pkt_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_packet_parser.sv
// Bench for uart_packet_parser: frame-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_packet_parser;

  localparam int unsigned MAXP = 8;
  localparam int unsigned TMO  = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            pkt_ready;
  logic            pkt_valid;
  logic [7:0]      pkt_cmd;
  logic [7:0]      pkt_len;
  logic [8*MAXP-1:0] pkt_payload;
  logic            chk_err, len_err, timeout_err, drop_err, busy;

  uart_packet_parser #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .pkt_ready   (pkt_ready),
    .pkt_valid   (pkt_valid),
    .pkt_cmd     (pkt_cmd),
    .pkt_len     (pkt_len),
    .pkt_payload (pkt_payload),
    .chk_err     (chk_err),
    .len_err     (len_err),
    .timeout_err (timeout_err),
    .drop_err    (drop_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: collects the bytes after SYNC and judges the frame
  // once its declared length is known to be complete.
  logic [7:0]  fq[$];
  bit          in_frame;
  int          gap;
  bit          m_good;
  logic [7:0]  m_x;
  logic        m_valid, m_chk, m_len_err, m_tmo, m_drop;
  logic [7:0]  m_cmd, m_len;
  logic [63:0] m_payload;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fq.delete();
      in_frame = 0; gap = 0;
      m_valid = 0; m_chk = 0; m_len_err = 0; m_tmo = 0; m_drop = 0;
      m_cmd = 0; m_len = 0; m_payload = 0;
    end else begin
      m_chk = 0; m_len_err = 0; m_tmo = 0; m_drop = 0; m_good = 0;
      if (rx_valid) begin
        gap = 0;
        if (!in_frame) begin
          if (rx_data == 8'hA5) begin
            in_frame = 1;
            fq.delete();
          end
        end else begin
          fq.push_back(rx_data);
          if (fq.size() == 2 && fq[1] > MAXP) begin
            m_len_err = 1;
            in_frame  = 0;
          end else if (fq.size() >= 2 && fq.size() == int'(fq[1]) + 3) begin
            m_x = 0;
            for (int i = 0; i < fq.size() - 1; i++) m_x ^= fq[i];
            if (m_x == fq[fq.size()-1]) m_good = 1;
            else m_chk = 1;
            in_frame = 0;
          end
        end
      end else if (in_frame) begin
        gap++;
        if (gap > TMO) begin
          m_tmo    = 1;
          in_frame = 0;
        end
      end
      if (m_good) begin
        if (!m_valid || pkt_ready) begin
          m_valid   = 1;
          m_cmd     = fq[0];
          m_len     = fq[1];
          m_payload = 0;
          for (int i = 0; i < int'(fq[1]); i++) m_payload[8*i +: 8] = fq[2+i];
        end else begin
          m_drop = 1;
        end
      end else if (m_valid && pkt_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("pkt_valid", pkt_valid, m_valid);
    check("chk_err", chk_err, m_chk);
    check("len_err", len_err, m_len_err);
    check("timeout_err", timeout_err, m_tmo);
    check("drop_err", drop_err, m_drop);
    check("busy", busy, in_frame);
    if (m_valid) begin
      check("pkt_cmd", pkt_cmd, m_cmd);
      check("pkt_len", pkt_len, m_len);
      check("pkt_payload", pkt_payload, m_payload);
    end
  end

  bit rand_rdy;

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_rdy) pkt_ready = 1'($urandom);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  logic [7:0]  fr[$];
  logic [7:0]  cs, gb;
  int unsigned ln, kind, g;

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; pkt_ready = 1'b0; rand_rdy = 0;
    tick(); tick();
    check("reset_valid", pkt_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_payload", pkt_payload, 0);
    reset = 1'b0;
    tick();

    // basic good frame, checksum 10^03^11^22^33 = 13
    pkt_ready = 1'b1;
    send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("t1_before_chk", pkt_valid, 0);
    send(8'h13);
    check("t1_valid", pkt_valid, 1);
    check("t1_cmd", pkt_cmd, 8'h10);
    check("t1_len", pkt_len, 8'h03);
    check("t1_payload", pkt_payload, 64'h0000_0000_0033_2211);
    check("t1_model_payload", m_payload, 64'h0000_0000_0033_2211);
    check("t1_no_chk_err", chk_err, 0);
    tick();
    check("t1_transferred", pkt_valid, 0);

    // zero-length frames
    send(8'hA5); send(8'h42); send(8'h00); send(8'h42);
    check("t2_valid", pkt_valid, 1);
    check("t2_cmd", pkt_cmd, 8'h42);
    check("t2_len", pkt_len, 0);
    check("t2_payload", pkt_payload, 0);
    tick();
    send(8'hA5); send(8'h42); send(8'h00); send(8'h43);
    check("t2_chk_err", chk_err, 1);
    check("t2_model_chk", m_chk, 1);
    check("t2_no_valid", pkt_valid, 0);
    check("t2_idle", busy, 0);

    // length error then recovery
    send(8'hA5); send(8'h01); send(8'h09);
    check("t3_len_err", len_err, 1);
    check("t3_idle", busy, 0);
    send(8'hA5); send(8'h01); send(8'h01); send(8'hFF); send(8'hFF);
    check("t3_valid", pkt_valid, 1);
    check("t3_len", pkt_len, 1);
    check("t3_payload", pkt_payload, 64'hFF);
    tick();

    // timeout boundary
    send(8'hA5); send(8'h07);
    repeat (TMO) tick();
    check("t4_still_busy", busy, 1);
    check("t4_no_tmo_yet", timeout_err, 0);
    tick();
    check("t4_tmo", timeout_err, 1);
    check("t4_idle", busy, 0);
    tick();
    check("t4_tmo_one_cycle", timeout_err, 0);
    send(8'hA5); send(8'h07);
    repeat (TMO) tick();
    send(8'h00); send(8'h07);
    check("t4_saved_valid", pkt_valid, 1);
    check("t4_saved_cmd", pkt_cmd, 8'h07);
    tick();

    // backpressure
    pkt_ready = 1'b0;
    send(8'hA5); send(8'h20); send(8'h01); send(8'h55); send(8'h74);
    check("t5_first_valid", pkt_valid, 1);
    send(8'hA5); send(8'h21); send(8'h01); send(8'h66); send(8'h46);
    check("t5_drop", drop_err, 1);
    check("t5_held_cmd", pkt_cmd, 8'h20);
    check("t5_held_payload", pkt_payload, 64'h55);
    tick();
    check("t5_drop_one_cycle", drop_err, 0);
    send(8'hA5); send(8'h22); send(8'h02); send(8'h01); send(8'h02);
    pkt_ready = 1'b1;
    send(8'h23);
    check("t5_reload_valid", pkt_valid, 1);
    check("t5_reload_cmd", pkt_cmd, 8'h22);
    check("t5_reload_payload", pkt_payload, 64'h0201);
    check("t5_no_drop", drop_err, 0);
    tick();
    check("t5_transferred", pkt_valid, 0);

    // reset mid-frame with a packet held
    pkt_ready = 1'b0;
    send(8'hA5); send(8'h30); send(8'h00); send(8'h30);
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11);
    reset = 1'b1;
    #1;
    check("t6_reset_valid", pkt_valid, 0);
    check("t6_reset_busy", busy, 0);
    check("t6_reset_cmd", pkt_cmd, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_no_err", {chk_err, len_err, timeout_err, drop_err}, 0);
    pkt_ready = 1'b1;
    send(8'hA5); send(8'h10); send(8'h01); send(8'hAA); send(8'hBB);
    check("t6_valid", pkt_valid, 1);
    check("t6_payload", pkt_payload, 64'hAA);
    tick();

    // random traffic with random backpressure and occasional long gaps
    rand_rdy = 1;
    repeat (250) begin
      if ($urandom_range(0, 3) == 0) begin
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h00;
        send(gb);
      end
      kind = $urandom_range(0, 9);
      ln   = (kind == 0) ? $urandom_range(MAXP + 1, 255) : $urandom_range(0, MAXP);
      fr.delete();
      fr.push_back(8'hA5);
      fr.push_back(8'($urandom));
      fr.push_back(8'(ln));
      if (kind != 0) begin
        for (int unsigned i = 0; i < ln; i++) fr.push_back(8'($urandom));
        cs = 0;
        for (int i = 1; i < fr.size(); i++) cs ^= fr[i];
        if (kind == 1) cs ^= 8'(1 << $urandom_range(0, 7));
        fr.push_back(cs);
      end
      foreach (fr[i]) begin
        send(fr[i]);
        g = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 2);
        repeat (g) tick();
      end
    end
    rand_rdy  = 0;
    pkt_ready = 1'b1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
